fifo_frame_reader: RTL and testbench



---
 rtl/fifo_frame_reader.sv | 65 ++++++
 tb/tb_fifo_frame_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains a synchronous FIFO into a 2-entry skid buffer and streams framed words downstream
// Ports: clk, rst_n (sync, active-low); i_enable permits pops; i_fifo_empty / o_fifo_pop / i_fifo_data form the
// FIFO read side (data one cycle after pop); o_valid / i_ready / o_data / o_last form the output stream;
// o_frame_cnt counts completed frames (16-bit wrap); o_busy is high while the FSM is RUN or DRAIN.
module fifo_frame_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_pop,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_busy
);
  localparam int IW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  head;
  logic [1:0]            occ;
  logic                  inflight;
  logic [IW-1:0]         idx;
  logic                  xfer;
  logic [1:0]            occ_n;
  logic                  tail;
  assign o_valid = occ != 2'd0;
  assign xfer = o_valid & i_ready;
  // Occupancy after this edge: in-flight capture adds one, a transfer removes one. Never exceeds 2.
  assign occ_n = occ + {1'b0, inflight} - {1'b0, xfer};
  // A pop now lands next cycle, so only pop if that word is guaranteed a slot.
  assign o_fifo_pop = rst_n & i_enable & ~i_fifo_empty & (state != FLUSH) & (occ_n < 2'd2);
  // Tail sits occ slots past head; with occ=2 no word is ever in flight.
  assign tail = head ^ occ[0];
  assign o_data = mem[head];
  assign o_last = o_valid & (idx == IW'(FRAME_LEN - 1));
  assign o_busy = (state == RUN) | (state == DRAIN);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem[0]      <= '0;
      mem[1]      <= '0;
      head        <= 1'b0;
      occ         <= 2'd0;
      inflight    <= 1'b0;
      idx         <= '0;
      o_frame_cnt <= 16'd0;
    end else begin
      if (inflight) mem[tail] <= i_fifo_data;
      head        <= head ^ xfer;
      occ         <= occ_n;
      inflight    <= o_fifo_pop;
      idx         <= xfer ? (o_last ? '0 : idx + 1'b1) : idx;
      o_frame_cnt <= o_frame_cnt + {15'd0, xfer & o_last};
      // With enable low no pop is issued, so pending work after this edge is exactly occ_n.
      state       <= i_enable ? RUN : (o_busy && occ_n != 2'd0) ? DRAIN : IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed self-checking bench with a behavioural FIFO and an output scoreboard
module tb_fifo_frame_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, enable, ready, pop, valid, last, busy, fifo_empty;
  logic [15:0] fifo_data = 16'd0;
  logic [15:0] data, frame_cnt;
  logic        en1, pop1, valid1, last1, busy1;
  logic [15:0] data1, cnt1;
  logic [15:0] fmem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [15:0] rx_d [0:255];
  logic        rx_l [0:255];
  int          rx_n = 0;
  int          checks = 0;
  int          errors = 0;
  int          base;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_fifo_empty(fifo_empty), .o_fifo_pop(pop),
    .i_fifo_data(fifo_data), .o_valid(valid), .i_ready(ready), .o_data(data), .o_last(last),
    .o_frame_cnt(frame_cnt), .o_busy(busy)
  );

  fifo_frame_reader #(.DATA_WIDTH(16), .FRAME_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_enable(en1), .i_fifo_empty(1'b0), .o_fifo_pop(pop1),
    .i_fifo_data(16'h0000), .o_valid(valid1), .i_ready(1'b1), .o_data(data1), .o_last(last1),
    .o_frame_cnt(cnt1), .o_busy(busy1)
  );

  always @(posedge clk) begin
    if (pop) begin
      fifo_data <= fmem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
    if (rst_n && valid && ready) begin
      rx_d[rx_n[7:0]] <= data;
      rx_l[rx_n[7:0]] <= last;
      rx_n <= rx_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] w);
    fmem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ready = 1'b1; en1 = 1'b0;
    push(16'hA5A5);
    cyc(3);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop", pop, 0);
    rst_n = 1'b1;
    #1;
    chk("n_pop", pop, 1);
    chk("n_valid", valid, 0);
    chk("n_busy", busy, 0);
    cyc();
    chk("n1_pop", pop, 0);
    chk("n1_valid", valid, 0);
    chk("n1_busy", busy, 1);
    cyc();
    chk("n2_valid", valid, 1);
    chk("n2_data", data, 16'hA5A5);
    chk("n2_last", last, 0);
    cyc();
    chk("n3_valid", valid, 0);
    chk("n3_cnt", frame_cnt, 0);

    rst_n = 1'b0; enable = 1'b0;
    cyc(2);
    for (int i = 1; i <= 16; i++) push(i[15:0]);
    rst_n = 1'b1; enable = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      chk("s_pop", pop, k < 16);
      chk("s_valid", valid, k >= 2 && k <= 17);
      if (k >= 2 && k <= 17) chk("s_data", data, k - 1);
      chk("s_last", last, k == 9 || k == 17);
      cyc();
    end
    chk("s_cnt", frame_cnt, 2);

    base = rx_n;
    for (int i = 0; i < 12; i++) push(16'h0021 + i[15:0]);
    #1;
    chk("bp_pop0", pop, 1);
    cyc(4);
    ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_pop", pop, 0);
      chk("bp_valid", valid, 1);
      chk("bp_data", data, 16'h0023);
      cyc();
    end
    ready = 1'b1;
    #1;
    chk("bp_resume_pop", pop, 1);
    cyc(20);
    chk("bp_count", rx_n - base, 12);
    for (int i = 0; i < 12; i++) chk("bp_order", rx_d[base + i], 16'h0021 + i);
    chk("bp_last", rx_l[base + 7], 1);
    chk("bp_cnt", frame_cnt, 3);

    rst_n = 1'b0;
    cyc(2);
    for (int i = 1; i <= 10; i++) push(i[15:0]);
    base = rx_n;
    rst_n = 1'b1;
    #1;
    chk("en_pop0", pop, 1);
    cyc(3);
    enable = 1'b0;
    #1;
    chk("en_e3_pop", pop, 0);
    chk("en_e3_data", data, 2);
    chk("en_e3_busy", busy, 1);
    cyc();
    chk("en_e4_pop", pop, 0);
    chk("en_e4_data", data, 3);
    chk("en_e4_busy", busy, 1);
    cyc();
    chk("en_e5_valid", valid, 0);
    chk("en_e5_busy", busy, 0);
    cyc(3);
    chk("en_idle_pop", pop, 0);
    enable = 1'b1;
    #1;
    chk("en_re_pop", pop, 1);
    cyc(20);
    chk("en_count", rx_n - base, 10);
    for (int i = 0; i < 10; i++) chk("en_order", rx_d[base + i], i + 1);
    chk("en_last8", rx_l[base + 7], 1);
    chk("en_last7", rx_l[base + 6], 0);
    chk("en_cnt", frame_cnt, 1);

    rst_n = 1'b0; enable = 1'b0;
    cyc(2);
    for (int i = 0; i < 40; i++) push(16'h0100 + i[15:0]);
    base = rx_n;
    rst_n = 1'b1; enable = 1'b1;
    for (int t = 0; t < 100 && rx_n < base + 29; t++) cyc();
    chk("mid_reach", rx_n - base, 29);
    ready = 1'b0;
    cyc(3);
    chk("mid_cnt", frame_cnt, 3);
    chk("mid_valid", valid, 1);
    chk("mid_data", data, 16'h011D);
    chk("mid_last", last, 0);
    rst_n = 1'b0;
    cyc(2);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pop", pop, 0);
    base = rx_n;
    rst_n = 1'b1; ready = 1'b1;
    #1;
    chk("mid_rel_cnt", frame_cnt, 0);
    for (int t = 0; t < 100 && rx_n < base + 8; t++) cyc();
    chk("mid_rel_reach", rx_n - base >= 8, 1);
    chk("mid_rel_first", rx_d[base], 16'h011F);
    chk("mid_rel_l0", rx_l[base], 0);
    chk("mid_rel_l6", rx_l[base + 6], 0);
    chk("mid_rel_l7", rx_l[base + 7], 1);
    chk("mid_rel_cnt1", frame_cnt, 1);
    enable = 1'b0;

    chk("wrap_start", cnt1, 0);
    en1 = 1'b1;
    for (int t = 0; t < 70000 && cnt1 != 16'hFFFF; t++) cyc();
    chk("wrap_pre", cnt1, 16'hFFFF);
    chk("wrap_last", last1, 1);
    cyc();
    chk("wrap", cnt1, 16'h0000);
    en1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
